chip_valve_sequencer: RTL

- Pneumatic control-side sequencer for the ChIP chip family; drives the chip's air (`*_ctrl`) and pump lines from a simple command stream.
- Converts opcodes into timed valve states, settle waits and a 3-phase peristaltic pump pattern shared by all reaction chambers.
- Sits between the host/firmware command FIFO and the off-chip solenoid drivers.

---
 rtl/chip_valve_sequencer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/chip_valve_sequencer.sv
// Command-driven pneumatic valve and 3-phase peristaltic pump sequencer for ChIP chips.
// Optional build macro CHIP_VALVE_SEQ_REVERSE_EN: PUMP arg MSB selects reverse phase order.
module chip_valve_sequencer #(
  parameter int NUM_INLETS    = 5,
  parameter int STEP_CYCLES   = 100,
  parameter int SETTLE_CYCLES = 50,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [CNT_W-1:0]      cmd_arg,
  output logic                  done,
  output logic                  err,
  output logic                  busy,
  output logic [NUM_INLETS-1:0] inlet_ctrl,
  output logic                  stage_inlet_ctrl,
  output logic                  stage_outlet_ctrl,
  output logic                  collect_ctrl,
  output logic [2:0]            pump
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_PUMP, S_HOLD, S_DONE} state_t;
  typedef enum logic {P_DONE, P_PUMP} pend_t;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_SELECT    = 3'd1;
  localparam logic [2:0] OP_PUMP      = 3'd2;
  localparam logic [2:0] OP_COLLECT   = 3'd3;
  localparam logic [2:0] OP_CLOSE_ALL = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LOAD   = CNT_W'(STEP_CYCLES - 1);

  state_t                  r_state;
  pend_t                   r_pend;
  logic [CNT_W-1:0]        r_tmr;
  logic [CNT_W-1:0]        r_opcnt;
  logic [2:0]              r_phase;
  logic                    r_rev;
  logic                    r_err_pend;
  logic                    r_done;
  logic                    r_err;
  logic [NUM_INLETS-1:0]   r_inlet;
  logic                    r_stage_in;
  logic                    r_stage_out;
  logic                    r_collect;
  logic [2:0]              r_pump;

  logic [NUM_INLETS-1:0]   w_sel_mask;
  logic                    w_sel_ok;
  logic                    w_rev;
  logic [CNT_W-1:0]        w_strokes;

  // Pump phase pattern; reverse mode walks the same table from the end.
  function automatic logic [2:0] phase_pat(input logic [2:0] idx, input logic rev);
    logic [2:0] k;
    k = rev ? (3'd5 - idx) : idx;
    case (k)
      3'd0:    phase_pat = 3'b110;
      3'd1:    phase_pat = 3'b100;
      3'd2:    phase_pat = 3'b101;
      3'd3:    phase_pat = 3'b001;
      3'd4:    phase_pat = 3'b011;
      3'd5:    phase_pat = 3'b010;
      default: phase_pat = 3'b111;
    endcase
  endfunction

`ifdef CHIP_VALVE_SEQ_REVERSE_EN
  assign w_rev     = cmd_arg[CNT_W-1];
  assign w_strokes = {1'b0, cmd_arg[CNT_W-2:0]};
`else
  assign w_rev     = 1'b0;
  assign w_strokes = cmd_arg;
`endif

  assign w_sel_ok = (cmd_arg != CNT_ZERO) && (cmd_arg <= CNT_W'(NUM_INLETS));

  // One-hot-low inlet mask decoded from the 1-based inlet index.
  always_comb begin
    w_sel_mask = {NUM_INLETS{1'b1}};
    for (int i = 0; i < NUM_INLETS; i++) begin
      if (cmd_arg == CNT_W'(i + 1)) w_sel_mask[i] = 1'b0;
      else                          w_sel_mask[i] = 1'b1;
    end
  end

  // Sequencer state machine with registered valve outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pend      <= P_DONE;
      r_tmr       <= CNT_ZERO;
      r_opcnt     <= CNT_ZERO;
      r_phase     <= 3'd0;
      r_rev       <= 1'b0;
      r_err_pend  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_inlet     <= {NUM_INLETS{1'b1}};
      r_stage_in  <= 1'b1;
      r_stage_out <= 1'b1;
      r_collect   <= 1'b1;
      r_pump      <= 3'b111;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_err_pend <= 1'b0;
            r_pend     <= P_DONE;
            r_tmr      <= SETTLE_LOAD;
            case (cmd_op)
              OP_NOP: r_state <= S_DONE;
              OP_SELECT: begin
                if (w_sel_ok) begin
                  r_inlet    <= w_sel_mask;
                  r_stage_in <= 1'b0;
                  r_state    <= S_SETTLE;
                end else begin
                  r_err_pend <= 1'b1;
                  r_state    <= S_DONE;
                end
              end
              OP_PUMP: begin
                r_stage_out <= 1'b0;
                r_opcnt     <= w_strokes;
                r_rev       <= w_rev;
                r_pend      <= P_PUMP;
                r_state     <= S_SETTLE;
              end
              OP_COLLECT: begin
                r_collect <= 1'b0;
                r_opcnt   <= cmd_arg;
                r_state   <= S_HOLD;
              end
              OP_CLOSE_ALL: begin
                r_inlet     <= {NUM_INLETS{1'b1}};
                r_stage_in  <= 1'b1;
                r_stage_out <= 1'b1;
                r_collect   <= 1'b1;
                r_pump      <= 3'b111;
                r_state     <= S_SETTLE;
              end
              default: begin
                r_err_pend <= 1'b1;
                r_state    <= S_DONE;
              end
            endcase
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SETTLE: begin
          if (r_tmr != CNT_ZERO) begin
            r_tmr <= r_tmr - CNT_ONE;
          end else if (r_pend == P_PUMP) begin
            // Zero strokes: close the outlet straight away and settle again.
            if (r_opcnt == CNT_ZERO) begin
              r_stage_out <= 1'b1;
              r_pump      <= 3'b111;
              r_tmr       <= SETTLE_LOAD;
              r_pend      <= P_DONE;
            end else begin
              r_phase <= 3'd0;
              r_pump  <= phase_pat(3'd0, r_rev);
              r_tmr   <= STEP_LOAD;
              r_state <= S_PUMP;
            end
          end else begin
            r_state <= S_DONE;
          end
        end
        S_PUMP: begin
          if (r_tmr != CNT_ZERO) begin
            r_tmr <= r_tmr - CNT_ONE;
          end else if (r_phase != 3'd5) begin
            r_phase <= r_phase + 3'd1;
            r_pump  <= phase_pat(r_phase + 3'd1, r_rev);
            r_tmr   <= STEP_LOAD;
          end else begin
            r_opcnt <= r_opcnt - CNT_ONE;
            r_phase <= 3'd0;
            if (r_opcnt == CNT_ONE) begin
              r_pump      <= 3'b111;
              r_stage_out <= 1'b1;
              r_tmr       <= SETTLE_LOAD;
              r_pend      <= P_DONE;
              r_state     <= S_SETTLE;
            end else begin
              r_pump <= phase_pat(3'd0, r_rev);
              r_tmr  <= STEP_LOAD;
            end
          end
        end
        S_HOLD: begin
          // A hold of 0 or 1 still opens the collect valve for one clock.
          if (r_opcnt > CNT_ONE) begin
            r_opcnt <= r_opcnt - CNT_ONE;
          end else begin
            r_collect <= 1'b1;
            r_tmr     <= SETTLE_LOAD;
            r_pend    <= P_DONE;
            r_state   <= S_SETTLE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_err   <= r_err_pend;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready         = (r_state == S_IDLE);
  assign busy              = (r_state != S_IDLE);
  assign done              = r_done;
  assign err               = r_err;
  assign inlet_ctrl        = r_inlet;
  assign stage_inlet_ctrl  = r_stage_in;
  assign stage_outlet_ctrl = r_stage_out;
  assign collect_ctrl      = r_collect;
  assign pump              = r_pump;

endmodule
